// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and defaults for the FIFO arbiter
// Purpose: FSM state encoding and default data width / depth.
// Ports:   none (package).
package fifo_arb_pkg;

    localparam int DW_DEF    = 4;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        RDONE
    } state_e;

endpackage

// File: rtl/fifo_arbiter_rr_arb2.sv
// rtl/fifo_arbiter_rr_arb2.sv - two-way round-robin picker
// Purpose: picks one of two eligible requesters; rr selects the favoured one.
// Ports:   elig  - eligible vector
//          rr    - favoured requester when both are eligible
//          grant - one-hot grant (zero when nothing is eligible)
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       rr,
    output logic [1:0] grant
);

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = rr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// rtl/fifo_arbiter.sv - shares one FIFO between two writers and one reader
// Purpose: sequences FIFO push/pop strobes, round-robins the writers,
//          alternates reads against writes and returns popped data.
// Ports:   clk, rst (sync, active-low)
//          req_wr/din0/din1/ack_wr      - write requesters
//          req_rd/dout/dout_valid       - read requester
//          f_en_in/f_in/f_en_out        - FIFO control outputs
//          f_out/f_empty/f_full         - FIFO outputs and flags
//          level                        - occupancy (only with FIFO_ARB_LEVEL_EN)
// Config:  FIFO_ARB_LEVEL_EN adds the level port and its counter.
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_wr,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic [1:0]    ack_wr,
    input  logic          req_rd,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          f_en_in,
    output logic [DW-1:0] f_in,
    output logic          f_en_out,
    input  logic [DW-1:0] f_out,
    input  logic          f_empty,
    input  logic          f_full
`ifdef FIFO_ARB_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

    state_e        state_q, state_d;
    logic [1:0]    ack_wr_q, ack_wr_d;
    logic          f_en_in_q, f_en_in_d;
    logic          f_en_out_q, f_en_out_d;
    logic [DW-1:0] f_in_q, f_in_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          rr_q, rr_d;
    logic          last_rd_q, last_rd_d;

    logic [1:0]    wr_elig;
    logic          rd_elig;
    logic [1:0]    grant;

    assign wr_elig = req_wr & {2{~f_full}};
    assign rd_elig = req_rd & ~f_empty;

    rr_arb2 u_rr_arb2 (
        .elig  (wr_elig),
        .rr    (rr_q),
        .grant (grant)
    );

    always_comb begin
        state_d      = state_q;
        ack_wr_d     = 2'b00;
        f_en_in_d    = 1'b0;
        f_en_out_d   = 1'b0;
        f_in_d       = f_in_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        rr_d         = rr_q;
        last_rd_d    = last_rd_q;
        case (state_q)
            IDLE: begin
                // A write goes first unless a read is also eligible and
                // the previous operation was a write.
                if ((|wr_elig) && (!rd_elig || last_rd_q)) begin
                    ack_wr_d  = grant;
                    f_en_in_d = 1'b1;
                    f_in_d    = grant[1] ? din1 : din0;
                    rr_d      = grant[0];
                    last_rd_d = 1'b0;
                    state_d   = WR;
                end else if (rd_elig) begin
                    f_en_out_d = 1'b1;
                    last_rd_d  = 1'b1;
                    state_d    = RD;
                end
            end
            WR:  state_d = IDLE;
            RD:  state_d = CAP;
            CAP: begin
                // f_out was refreshed by the edge that ended the pop cycle.
                dout_d       = f_out;
                dout_valid_d = 1'b1;
                state_d      = RDONE;
            end
            RDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef FIFO_ARB_LEVEL_EN
    localparam int LW = $clog2(DEPTH+1);
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        if (f_en_in_q && (level_q != LW'(DEPTH))) begin
            level_d = level_q + 1'b1;
        end else if (f_en_out_q && (level_q != '0)) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            ack_wr_q     <= 2'b00;
            f_en_in_q    <= 1'b0;
            f_en_out_q   <= 1'b0;
            f_in_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rr_q         <= 1'b0;
            last_rd_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            ack_wr_q     <= ack_wr_d;
            f_en_in_q    <= f_en_in_d;
            f_en_out_q   <= f_en_out_d;
            f_in_q       <= f_in_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            rr_q         <= rr_d;
            last_rd_q    <= last_rd_d;
        end
    end

    assign ack_wr     = ack_wr_q;
    assign f_en_in    = f_en_in_q;
    assign f_en_out   = f_en_out_q;
    assign f_in       = f_in_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb/tb_fifo_arbiter.sv - directed self-checking bench for fifo_arbiter
module tb_fifo_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req_wr = 2'b00;
    logic [3:0] din0 = 4'h0;
    logic [3:0] din1 = 4'h0;
    logic [1:0] ack_wr;
    logic       req_rd = 1'b0;
    logic [3:0] dout;
    logic       dout_valid;
    logic       f_en_in;
    logic [3:0] f_in;
    logic       f_en_out;
    logic [3:0] f_out;
    logic       f_empty;
    logic       f_full;
`ifdef FIFO_ARB_LEVEL_EN
    logic [3:0] level;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fifo_arbiter #(.DW(4), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_wr     (req_wr),
        .din0       (din0),
        .din1       (din1),
        .ack_wr     (ack_wr),
        .req_rd     (req_rd),
        .dout       (dout),
        .dout_valid (dout_valid),
        .f_en_in    (f_en_in),
        .f_in       (f_in),
        .f_en_out   (f_en_out),
        .f_out      (f_out),
        .f_empty    (f_empty),
        .f_full     (f_full)
`ifdef FIFO_ARB_LEVEL_EN
        ,
        .level      (level)
`endif
    );

    // Behavioural 8-deep FIFO with a registered output word.
    logic [3:0] mem [0:7];
    logic [2:0] wp, rp;
    logic [3:0] cnt;
    logic       push, pop;
    assign push    = f_en_in && (cnt != 4'd8);
    assign pop     = f_en_out && (cnt != 4'd0);
    assign f_empty = (cnt == 4'd0);
    assign f_full  = (cnt == 4'd8);

    always @(posedge clk) begin
        if (!rst) begin
            wp    <= 3'd0;
            rp    <= 3'd0;
            cnt   <= 4'd0;
            f_out <= 4'h0;
        end else begin
            if (push) begin
                mem[wp] <= f_in;
                wp      <= wp + 3'd1;
            end
            if (pop) begin
                f_out <= mem[rp];
                rp    <= rp + 3'd1;
            end
            cnt <= cnt + {3'b000, push} - {3'b000, pop};
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        req_wr = 2'b00;
        req_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issues one write from an IDLE negedge and returns at the next IDLE negedge.
    task automatic do_write(input int who, input logic [3:0] d);
        if (who == 0) begin
            din0   = d;
            req_wr = 2'b01;
        end else begin
            din1   = d;
            req_wr = 2'b10;
        end
        @(negedge clk);
        req_wr = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ack_wr !== 2'b00) $display("FAIL reset_ack: got %b want 00", ack_wr); else n_pass++;
        n_checks++; if (f_en_in !== 1'b0) $display("FAIL reset_en_in: got %b want 0", f_en_in); else n_pass++;
        n_checks++; if (f_en_out !== 1'b0) $display("FAIL reset_en_out: got %b want 0", f_en_out); else n_pass++;
        n_checks++; if (f_in !== 4'h0) $display("FAIL reset_f_in: got %h want 0", f_in); else n_pass++;
        n_checks++; if (dout !== 4'h0) $display("FAIL reset_dout: got %h want 0", dout); else n_pass++;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_valid); else n_pass++;
`ifdef FIFO_ARB_LEVEL_EN
        n_checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
`endif
    endtask

    task automatic test_single_write();
        do_reset();
        din0   = 4'h2;
        req_wr = 2'b01;
        @(negedge clk);
        n_checks++; if (ack_wr !== 2'b01) $display("FAIL wr_ack: got %b want 01", ack_wr); else n_pass++;
        n_checks++; if (f_en_in !== 1'b1) $display("FAIL wr_en_in: got %b want 1", f_en_in); else n_pass++;
        n_checks++; if (f_in !== 4'h2) $display("FAIL wr_f_in: got %h want 2", f_in); else n_pass++;
        n_checks++; if (f_en_out !== 1'b0) $display("FAIL wr_en_out: got %b want 0", f_en_out); else n_pass++;
        req_wr = 2'b00;
        @(negedge clk);
        n_checks++; if (ack_wr !== 2'b00) $display("FAIL wr_ack_pulse: got %b want 00", ack_wr); else n_pass++;
        n_checks++; if (f_en_in !== 1'b0) $display("FAIL wr_en_in_pulse: got %b want 0", f_en_in); else n_pass++;
`ifdef FIFO_ARB_LEVEL_EN
        n_checks++; if (level !== 4'd1) $display("FAIL wr_level: got %0d want 1", level); else n_pass++;
`endif
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ack [0:5];
        logic [3:0] exp_fin [0:5];
        exp_ack = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        exp_fin = '{4'h3, 4'h0, 4'h5, 4'h0, 4'h3, 4'h0};
        do_reset();
        din0   = 4'h3;
        din1   = 4'h5;
        req_wr = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) req_wr = 2'b00;
            n_checks++;
            if (ack_wr !== exp_ack[i]) $display("FAIL rr_ack[%0d]: got %b want %b", i, ack_wr, exp_ack[i]);
            else n_pass++;
            if (exp_ack[i] != 2'b00) begin
                n_checks++;
                if (f_in !== exp_fin[i]) $display("FAIL rr_f_in[%0d]: got %h want %h", i, f_in, exp_fin[i]);
                else n_pass++;
            end
        end
        @(negedge clk);
`ifdef FIFO_ARB_LEVEL_EN
        n_checks++; if (level !== 4'd3) $display("FAIL rr_level: got %0d want 3", level); else n_pass++;
`endif
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) do_write(0, 4'(i + 1));
`ifdef FIFO_ARB_LEVEL_EN
        n_checks++; if (level !== 4'd8) $display("FAIL full_level: got %0d want 8", level); else n_pass++;
`endif
        din0   = 4'h9;
        req_wr = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (ack_wr !== 2'b00 || f_en_in !== 1'b0) $display("FAIL full_no_ack[%0d]: got ack %b en_in %b want 00/0", i, ack_wr, f_en_in);
            else n_pass++;
        end
        req_rd = 1'b1;
        @(negedge clk);
        n_checks++; if (f_en_out !== 1'b1 || ack_wr !== 2'b00) $display("FAIL full_rd: got en_out %b ack %b want 1/00", f_en_out, ack_wr); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (dout_valid !== 1'b1 || dout !== 4'h1) $display("FAIL full_rd_data: got valid %b dout %h want 1/1", dout_valid, dout); else n_pass++;
        req_rd = 1'b0;
        @(negedge clk);
        n_checks++; if (ack_wr !== 2'b00) $display("FAIL full_idle: got %b want 00", ack_wr); else n_pass++;
        @(negedge clk);
        n_checks++; if (ack_wr !== 2'b01 || f_in !== 4'h9) $display("FAIL full_grant: got ack %b f_in %h want 01/9", ack_wr, f_in); else n_pass++;
        req_wr = 2'b00;
        @(negedge clk);
`ifdef FIFO_ARB_LEVEL_EN
        n_checks++; if (level !== 4'd8) $display("FAIL full_level_after: got %0d want 8", level); else n_pass++;
`endif
    endtask

    task automatic test_read_order();
        logic [3:0] exp_d [0:1];
        exp_d = '{4'h1, 4'h2};
        do_reset();
        do_write(0, 4'h1);
        do_write(1, 4'h2);
        for (int k = 0; k < 2; k++) begin
            req_rd = 1'b1;
            @(negedge clk);
            n_checks++; if (f_en_out !== 1'b1 || dout_valid !== 1'b0) $display("FAIL rd_pop[%0d]: got en_out %b valid %b want 1/0", k, f_en_out, dout_valid); else n_pass++;
            @(negedge clk);
            n_checks++; if (dout_valid !== 1'b0 || f_en_out !== 1'b0) $display("FAIL rd_cap[%0d]: got valid %b en_out %b want 0/0", k, dout_valid, f_en_out); else n_pass++;
            @(negedge clk);
            n_checks++; if (dout_valid !== 1'b1 || dout !== exp_d[k]) $display("FAIL rd_data[%0d]: got valid %b dout %h want 1/%h", k, dout_valid, dout, exp_d[k]); else n_pass++;
            req_rd = 1'b0;
            @(negedge clk);
            n_checks++; if (dout_valid !== 1'b0 || dout !== exp_d[k]) $display("FAIL rd_hold[%0d]: got valid %b dout %h want 0/%h", k, dout_valid, dout, exp_d[k]); else n_pass++;
        end
    endtask

    task automatic test_rd_vs_wr();
        do_reset();
        din1   = 4'h7;
        req_rd = 1'b1;
        req_wr = 2'b10;
        @(negedge clk);
        n_checks++; if (ack_wr !== 2'b10 || f_en_in !== 1'b1 || f_en_out !== 1'b0) $display("FAIL rw_write_first: got ack %b en_in %b en_out %b want 10/1/0", ack_wr, f_en_in, f_en_out); else n_pass++;
        req_wr = 2'b00;
        @(negedge clk);
        n_checks++; if (f_en_in !== 1'b0 || f_en_out !== 1'b0) $display("FAIL rw_gap: got en_in %b en_out %b want 0/0", f_en_in, f_en_out); else n_pass++;
        @(negedge clk);
        n_checks++; if (f_en_out !== 1'b1 || f_en_in !== 1'b0) $display("FAIL rw_read_next: got en_out %b en_in %b want 1/0", f_en_out, f_en_in); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (dout_valid !== 1'b1 || dout !== 4'h7) $display("FAIL rw_data: got valid %b dout %h want 1/7", dout_valid, dout); else n_pass++;
        req_rd = 1'b0;
        @(negedge clk);
        // After a write, a simultaneous read and write must favour the read.
        do_write(0, 4'h4);
        din0   = 4'hc;
        req_rd = 1'b1;
        req_wr = 2'b01;
        @(negedge clk);
        n_checks++; if (f_en_out !== 1'b1 || ack_wr !== 2'b00 || f_en_in !== 1'b0) $display("FAIL rw_read_wins: got en_out %b ack %b en_in %b want 1/00/0", f_en_out, ack_wr, f_en_in); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (dout_valid !== 1'b1 || dout !== 4'h4) $display("FAIL rw_data2: got valid %b dout %h want 1/4", dout_valid, dout); else n_pass++;
        req_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (ack_wr !== 2'b01 || f_in !== 4'hc || f_en_out !== 1'b0) $display("FAIL rw_write_after: got ack %b f_in %h en_out %b want 01/c/0", ack_wr, f_in, f_en_out); else n_pass++;
        req_wr = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_cap();
        do_reset();
        do_write(0, 4'h6);
        req_rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        req_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL cap_rst_valid: got %b want 0", dout_valid); else n_pass++;
        n_checks++; if (dout !== 4'h0) $display("FAIL cap_rst_dout: got %h want 0", dout); else n_pass++;
        n_checks++; if (f_en_out !== 1'b0 || f_en_in !== 1'b0) $display("FAIL cap_rst_strobes: got en_out %b en_in %b want 0/0", f_en_out, f_en_in); else n_pass++;
`ifdef FIFO_ARB_LEVEL_EN
        n_checks++; if (level !== 4'd0) $display("FAIL cap_rst_level: got %0d want 0", level); else n_pass++;
`endif
        @(negedge clk);
        n_checks++; if (dout_valid !== 1'b0 || dout !== 4'h0) $display("FAIL cap_rst_after: got valid %b dout %h want 0/0", dout_valid, dout); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_full();
        test_read_order();
        test_rd_vs_wr();
        test_reset_mid_cap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
